// File: rtl/disp_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Holds the scan FSM states, display geometry and nibble/blanking helpers.
package disp_pkg;

  typedef enum logic [1:0] {
    GUARD,
    ON,
    OFF
  } state_t;

  localparam int N_DIGITS = 4;
  localparam int N_SUB    = 16;

  // A digit is blanked only when it and every more significant nibble are zero.
  function automatic logic lz_suppressed(input logic [15:0] value,
                                         input logic [1:0]  idx,
                                         input logic        lz_en);
    logic hit;
    hit = 1'b0;
    case (idx)
      2'd1:    hit = (value[15:4] == 12'd0);
      2'd2:    hit = (value[15:8] == 8'd0);
      2'd3:    hit = (value[15:12] == 4'd0);
      default: hit = 1'b0;
    endcase
    return lz_en && hit;
  endfunction

  function automatic logic [3:0] nibble_of(input logic [15:0] value,
                                           input logic [1:0]  idx);
    return value[4*idx +: 4];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Subslot/slot/digit timebase for the display scanner.
// Produces the tick and boundary strobes plus current and next digit index.
module scan_timer
  import disp_pkg::*;
#(
  parameter int SUB_CYCLES = 6250
) (
  input  logic       clk,
  input  logic       reset,
  output logic       sub_tick,
  output logic       slot_start,
  output logic       slot_end,
  output logic       frame_end,
  output logic [3:0] sub_idx,
  output logic [1:0] digit_idx,
  output logic [1:0] digit_idx_next
);

  localparam int CNT_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SUB_CYCLES - 1);
  localparam logic [3:0]       SUB_LAST  = 4'(N_SUB - 1);
  localparam logic [1:0]       DIGIT_LAST = 2'(N_DIGITS - 1);

  logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [3:0]       sub_idx_q, sub_idx_d;
  logic [1:0]       digit_idx_q, digit_idx_d;

  always_comb begin
    sub_tick   = (sub_cnt_q == CNT_MAX);
    slot_end   = sub_tick && (sub_idx_q == SUB_LAST);
    frame_end  = slot_end && (digit_idx_q == DIGIT_LAST);
    slot_start = (sub_cnt_q == '0) && (sub_idx_q == 4'd0);

    sub_cnt_d   = sub_tick ? '0 : sub_cnt_q + CNT_W'(1);
    sub_idx_d   = sub_idx_q;
    digit_idx_d = digit_idx_q;
    if (slot_end) begin
      sub_idx_d   = 4'd0;
      digit_idx_d = (digit_idx_q == DIGIT_LAST) ? 2'd0 : digit_idx_q + 2'd1;
    end else if (sub_tick) begin
      sub_idx_d = sub_idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_cnt_q   <= '0;
      sub_idx_q   <= 4'd0;
      digit_idx_q <= 2'd0;
    end else begin
      sub_cnt_q   <= sub_cnt_d;
      sub_idx_q   <= sub_idx_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign sub_idx        = sub_idx_q;
  assign digit_idx      = digit_idx_q;
  assign digit_idx_next = digit_idx_d;

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: PWM brightness, ghost guard,
// leading-zero blanking and a frame-synchronous double-buffered value load.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SUB_CYCLES = 6250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  brightness,
  input  logic        lz_blank,
  output logic [3:0]  an_n,
  output logic [1:0]  digit_idx,
  output logic [3:0]  bcd,
  output logic        pending,
  output logic        frame_start
);

  logic       sub_tick, slot_start, slot_end, frame_end;
  logic [3:0] sub_idx;
  logic [1:0] digit_next;

  scan_timer #(.SUB_CYCLES(SUB_CYCLES)) u_timer (
    .clk            (clk),
    .reset          (reset),
    .sub_tick       (sub_tick),
    .slot_start     (slot_start),
    .slot_end       (slot_end),
    .frame_end      (frame_end),
    .sub_idx        (sub_idx),
    .digit_idx      (digit_idx),
    .digit_idx_next (digit_next)
  );

  state_t      state_q, state_d;
  logic [15:0] active_q, active_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  bri_q, bri_d;
  logic        pending_q, pending_d;
  logic [3:0]  an_n_q, an_n_d;
  logic [3:0]  bcd_q, bcd_d;
  logic        frame_start_q, frame_start_d;

  // Outputs are computed from next-cycle values so they line up with the counters.
  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      state_d = GUARD;
    end else if (sub_tick) begin
      case (state_q)
        GUARD:   state_d = (bri_q != 4'd0) ? ON : OFF;
        ON:      if (sub_idx == bri_q) state_d = OFF;
        OFF:     state_d = OFF;
        default: state_d = GUARD;
      endcase
    end

    bri_d    = slot_start ? brightness : bri_q;
    shadow_d = load ? value_in : shadow_q;
    active_d = (frame_end && pending_q) ? shadow_q : active_q;

    pending_d = pending_q;
    if (load)           pending_d = 1'b1;
    else if (frame_end) pending_d = 1'b0;

    // Anodes only move on subslot boundaries, which keeps the guard band clean.
    an_n_d = an_n_q;
    if (sub_tick) begin
      if (state_d == ON && !lz_suppressed(active_d, digit_next, lz_blank))
        an_n_d = ~(4'b0001 << digit_next);
      else
        an_n_d = 4'b1111;
    end

    bcd_d         = nibble_of(active_d, digit_next);
    frame_start_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= GUARD;
      active_q      <= 16'd0;
      shadow_q      <= 16'd0;
      bri_q         <= 4'd0;
      pending_q     <= 1'b0;
      an_n_q        <= 4'b1111;
      bcd_q         <= 4'd0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      bri_q         <= bri_d;
      pending_q     <= pending_d;
      an_n_q        <= an_n_d;
      bcd_q         <= bcd_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n        = an_n_q;
  assign bcd         = bcd_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the 4-digit seven-segment display. It owns digit scanning, anode enables, per-digit brightness (PWM), ghost-guard blanking, leading-zero suppression and a frame-synchronous, double-buffered load of the 16-bit display value. It replaces the free-running 2-bit counter/decoder/mux path and feeds `bcd` to the existing BCD-to-seven-segment converter, so the display is driven from the system clock with no derived clocks.

## Interface
- `SUB_CYCLES`, 6250: clock cycles per subslot. One digit slot is 16 subslots, so the default slot is 100 000 cycles (1 ms at 100 MHz). Must be ≥ 2.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `value_in`  in  16  four hex/BCD nibbles; nibble *k* drives digit *k*, digit 0 is least significant.
- `load`  in  1  one-cycle request to capture `value_in` into the shadow register.
- `brightness`  in  4  0 means dark; *b* lights the digit for *b* of 16 subslots.
- `lz_blank`  in  1  enables leading-zero suppression.
- `an_n`  out  4  active-low one-hot anode enables; 1111 means all off.
- `digit_idx`  out  2  digit currently scanned.
- `bcd`  out  4  nibble for `digit_idx`.
- `pending`  out  1  a loaded value is waiting for the frame boundary.
- `frame_start`  out  1  one-cycle pulse on the first cycle of the digit-0 slot.

## Operation
- **Registers:**
  - `active`: 16 bits, the displayed value.
  - `shadow`: 16 bits.
  - `bri_q`: 4 bits, brightness latched at each slot start.
- **Timing counters:**
  - `sub_cnt` counts 0..SUB_CYCLES-1.
  - `sub_idx` counts 0..15 and advances when `sub_cnt` wraps.
  - `digit_idx` advances 0→1→2→3→0 when `sub_idx` wraps from 15.
- **State machine:**
  - GUARD: `sub_idx` = 0. Anodes off.
  - ON: 1 ≤ `sub_idx` ≤ `bri_q`.
  - OFF: `sub_idx` > `bri_q`.
- **Transitions:**
  - GUARD→ON at the subslot tick if `bri_q` ≥ 1, otherwise GUARD→OFF.
  - ON→OFF at the tick where `sub_idx` becomes `bri_q`+1.
  - OFF or ON→GUARD at the slot end, where the next digit starts.
- **Anode drive:** in ON, `an_n` = ~(1<<`digit_idx`) unless the digit is suppressed. In every other state `an_n` = 1111.
- **Leading-zero suppression:** with `lz_blank`=1, digit *k* (k ≥ 1) is suppressed when all nibbles *k*..3 of `active` are 0. Digit 0 is never suppressed.
- **`bcd` output:** always equals `active[4*digit_idx +: 4]`, suppressed or not. Values A–F pass through unchanged.
- **Brightness:** `bri_q` latches `brightness` on the first cycle of every slot. Changes mid-slot take effect at the next slot.
- **Load handshake:**
  - `load`=1 writes `shadow` ← `value_in` and sets `pending`.
  - A load while `pending` is set overwrites `shadow`. Last write wins.
- **Commit:** on the last cycle of the digit-3 slot with `pending`=1, `active` ← `shadow` and `pending` clears.
- **Load on the commit cycle:** the previous `shadow` commits. The new value lands in `shadow` and `pending` stays 1 until the next frame.
- **Reset** (any cycle, mid-operation included): all counters 0, `active`=`shadow`=0, `bri_q`=0, state GUARD.

## Timing
- All outputs are registered.
- **Reset values:** `an_n`=1111, `digit_idx`=0, `bcd`=0, `pending`=0, `frame_start`=0.
- The first cycle after reset deasserts is cycle 0 of the digit-0 GUARD subslot. `frame_start` is 0 here; the first pulse comes at the second frame start.
- **`frame_start`:** high exactly on cycle 0 of each digit-0 slot after a wrap from digit 3.
- **Frame length:** 64·SUB_CYCLES cycles.
- **`pending` latency:** rises the cycle after `load`. Worst-case load-to-display latency is one frame plus one cycle.
- **Commit visibility:** the committed value is visible on `bcd` together with `frame_start`.
- **Anode timing:** `an_n` changes only on subslot boundaries. Two digits are never enabled in the same cycle. Every digit change is preceded by at least SUB_CYCLES cycles of 1111.

## Structure
- **Package `disp_pkg`:**
  - `state_t` enum: GUARD, ON, OFF.
  - `localparam N_DIGITS = 4`.
  - `localparam N_SUB = 16`.
- **Sub-module `scan_timer`:** owns `sub_cnt`, `sub_idx` and `digit_idx`. It outputs `sub_tick`, `slot_start` and `frame_end`.
- **Top level:** the FSM, registers and output logic.

## Test plan
All scenarios use SUB_CYCLES=4, giving a 64-cycle slot and a 256-cycle frame.
- Reset, `brightness`=15, no load → `an_n`=1111 for cycles 0–3, then 1110 for cycles 4–63, then 1111 for cycles 64–67, then 1101; `bcd`=0 throughout.
- `brightness`=0 → `an_n`=1111 for a full frame. `brightness`=1 → each digit is on for exactly 4 cycles (`sub_idx` 1). A `brightness` change mid-slot → the duty changes only at the next slot.
- `load` 0x0042 with `lz_blank`=1 → after commit, the digit-3/2 slots show `an_n`=1111 and the digit-1/0 slots show `bcd`=4/2 with `an_n`=1101/1110. With `lz_blank`=0, all four digits light.
- `load` 0x1234 at cycle 100 → `pending`=1 at cycle 101 while the display still shows 0. At cycle 256: `frame_start`=1, `bcd`=4, `active`=0x1234, `pending`=0.
- `load` 0xAAAA at cycle 100 and `load` 0x5555 on the commit cycle 255 → frame 2 shows 0xAAAA with `pending`=1; frame 3 shows 0x5555 with `pending`=0.
- `reset` asserted during an ON subslot of digit 2 with `pending`=1 → the next cycle has `an_n`=1111, `digit_idx`=0, `bcd`=0, `pending`=0.
